spio_uart_frac_baud_gen: RTL and testbench



---
 rtl/spio_uart_frac_baud_gen_pkg.sv | 14 +
 rtl/spio_uart_frac_baud_gen_if.sv | 36 +++
 rtl/spio_uart_frac_tick.sv | 48 ++++
 rtl/spio_uart_frac_baud_gen.sv | 99 +++++++++
 tb/tb_spio_uart_frac_baud_gen.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/spio_uart_frac_baud_gen_pkg.sv
// Shared UART baud-generator constants: default divisors for 115200 baud at 100 MHz,
// the default oversample ratio and the minimum usable integer divisor.
package spio_uart_frac_baud_gen_pkg;

    localparam int UART_OVERSAMPLE_DEF  = 8;
    localparam int UART_DIV_INT_115200  = 108;
    localparam int UART_DIV_FRAC_115200 = 130;
    localparam int UART_MIN_DIV_INT     = 2;

    function automatic int eff_div_int(input int d);
        return (d < UART_MIN_DIV_INT) ? UART_MIN_DIV_INT : d;
    endfunction

endpackage

// File: rtl/spio_uart_frac_baud_gen_if.sv
// Divisor-config handshake and pulse outputs of the fractional baud generator.
// UART_BAUD_GEN_PHASE_OUT_EN adds the PHASE_OUT signal for RX sample selection.
interface spio_uart_frac_baud_gen_if #(
    parameter int INT_BITS  = 12,
    parameter int FRAC_BITS = 8
`ifdef UART_BAUD_GEN_PHASE_OUT_EN
    , parameter int OVERSAMPLE = 8
`endif
);
    logic                 CFG_VALID_IN;
    logic                 CFG_READY_OUT;
    logic [INT_BITS-1:0]  CFG_DIV_INT_IN;
    logic [FRAC_BITS-1:0] CFG_DIV_FRAC_IN;
    logic                 SUBSAMPLE_PULSE_OUT;
    logic                 BAUD_PULSE_OUT;
`ifdef UART_BAUD_GEN_PHASE_OUT_EN
    logic [$clog2(OVERSAMPLE)-1:0] PHASE_OUT;
`endif

    modport slave (
        input  CFG_VALID_IN, CFG_DIV_INT_IN, CFG_DIV_FRAC_IN,
        output CFG_READY_OUT, SUBSAMPLE_PULSE_OUT, BAUD_PULSE_OUT
`ifdef UART_BAUD_GEN_PHASE_OUT_EN
        , output PHASE_OUT
`endif
    );

    modport master (
        output CFG_VALID_IN, CFG_DIV_INT_IN, CFG_DIV_FRAC_IN,
        input  CFG_READY_OUT, SUBSAMPLE_PULSE_OUT, BAUD_PULSE_OUT
`ifdef UART_BAUD_GEN_PHASE_OUT_EN
        , input PHASE_OUT
`endif
    );

endinterface

// File: rtl/spio_uart_frac_tick.sv
// Fractional-N ticker: down-counter plus phase accumulator; the accumulator carry
// stretches a period by one clock so the mean period is DIV_INT + DIV_FRAC/2^FRAC_BITS.
module spio_uart_frac_tick #(
    parameter int                  INT_BITS  = 12,
    parameter int                  FRAC_BITS = 8,
    parameter logic [INT_BITS-1:0] RST_CNT   = 12'd107
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_en,
    input  logic                 i_restart,
    input  logic [INT_BITS-1:0]  i_div_int,
    input  logic [FRAC_BITS-1:0] i_div_frac,
    output logic                 o_tick
);
    logic [INT_BITS-1:0]  r_cnt;
    logic [FRAC_BITS-1:0] r_acc;
    logic [FRAC_BITS:0]   w_sum;
    logic [INT_BITS-1:0]  w_reload;
    logic                 w_cnt_zero;

    always_comb begin
        w_sum      = {1'b0, r_acc} + {1'b0, i_div_frac};
        w_reload   = i_div_int - INT_BITS'(1) + INT_BITS'(w_sum[FRAC_BITS]);
        w_cnt_zero = (r_cnt == {INT_BITS{1'b0}});
    end

    // A restart cycle never emits a tick, even if the counter has expired.
    assign o_tick = i_en & ~i_restart & w_cnt_zero;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt <= RST_CNT;
            r_acc <= {FRAC_BITS{1'b0}};
        end else if (i_en) begin
            if (i_restart) begin
                r_cnt <= i_div_int - INT_BITS'(1);
                r_acc <= {FRAC_BITS{1'b0}};
            end else if (w_cnt_zero) begin
                r_cnt <= w_reload;
                r_acc <= w_sum[FRAC_BITS-1:0];
            end else begin
                r_cnt <= r_cnt - INT_BITS'(1);
            end
        end
    end

endmodule

// File: rtl/spio_uart_frac_baud_gen.sv
// Fractional-N UART subsample/baud generator with shadowed divisor reload and mid-bit resync.
// Optional UART_BAUD_GEN_PHASE_OUT_EN exposes the subsample phase on PHASE_OUT.
module spio_uart_frac_baud_gen
    import spio_uart_frac_baud_gen_pkg::*;
#(
    parameter int INT_BITS         = 12,
    parameter int FRAC_BITS        = 8,
    parameter int OVERSAMPLE       = UART_OVERSAMPLE_DEF,
    parameter int DEFAULT_DIV_INT  = UART_DIV_INT_115200,
    parameter int DEFAULT_DIV_FRAC = UART_DIV_FRAC_115200
) (
    input  logic CLK_IN,
    input  logic RESET_N_IN,
    input  logic ENABLE_IN,
    input  logic RESYNC_IN,
    spio_uart_frac_baud_gen_if.slave bus
);
    localparam int                   PH_W         = $clog2(OVERSAMPLE);
    localparam logic [INT_BITS-1:0]  RST_DIV_INT  = INT_BITS'(eff_div_int(DEFAULT_DIV_INT));
    localparam logic [FRAC_BITS-1:0] RST_DIV_FRAC = FRAC_BITS'(DEFAULT_DIV_FRAC);
    localparam logic [INT_BITS-1:0]  RST_CNT      = RST_DIV_INT - INT_BITS'(1);
    localparam logic [PH_W-1:0]      PH_LAST      = PH_W'(OVERSAMPLE - 1);
    localparam logic [PH_W-1:0]      PH_HALF      = PH_W'(OVERSAMPLE / 2);

    function automatic logic [INT_BITS-1:0] clamp_div_int(input logic [INT_BITS-1:0] d);
        if (d < INT_BITS'(UART_MIN_DIV_INT)) begin
            clamp_div_int = INT_BITS'(UART_MIN_DIV_INT);
        end else begin
            clamp_div_int = d;
        end
    endfunction

    logic [INT_BITS-1:0]  r_div_int,  r_shd_int,  w_use_int;
    logic [FRAC_BITS-1:0] r_div_frac, r_shd_frac, w_use_frac;
    logic                 r_shd_full;
    logic [PH_W-1:0]      r_phase;
    logic                 w_tick, w_baud, w_restart, w_apply, w_accept;

    // The shadow takes effect exactly at the reload it belongs to: baud, resync or idle.
    always_comb begin
        w_restart  = ENABLE_IN & RESYNC_IN;
        w_baud     = w_tick & (r_phase == PH_LAST);
        w_apply    = r_shd_full & (w_baud | w_restart | ~ENABLE_IN);
        w_accept   = bus.CFG_VALID_IN & ~r_shd_full;
        w_use_int  = w_apply ? r_shd_int  : r_div_int;
        w_use_frac = w_apply ? r_shd_frac : r_div_frac;
    end

    spio_uart_frac_tick #(
        .INT_BITS  (INT_BITS),
        .FRAC_BITS (FRAC_BITS),
        .RST_CNT   (RST_CNT)
    ) u_tick (
        .i_clk      (CLK_IN),
        .i_rst_n    (RESET_N_IN),
        .i_en       (ENABLE_IN),
        .i_restart  (w_restart),
        .i_div_int  (w_use_int),
        .i_div_frac (w_use_frac),
        .o_tick     (w_tick)
    );

    always_ff @(posedge CLK_IN) begin
        if (!RESET_N_IN) begin
            r_div_int  <= RST_DIV_INT;
            r_div_frac <= RST_DIV_FRAC;
            r_shd_int  <= RST_DIV_INT;
            r_shd_frac <= RST_DIV_FRAC;
            r_shd_full <= 1'b0;
        end else if (w_apply) begin
            r_div_int  <= r_shd_int;
            r_div_frac <= r_shd_frac;
            r_shd_full <= 1'b0;
        end else if (w_accept) begin
            r_shd_int  <= clamp_div_int(bus.CFG_DIV_INT_IN);
            r_shd_frac <= bus.CFG_DIV_FRAC_IN;
            r_shd_full <= 1'b1;
        end
    end

    // Phase counts subsamples; resync parks it mid-bit so the next baud lands half a bit later.
    always_ff @(posedge CLK_IN) begin
        if (!RESET_N_IN) begin
            r_phase <= {PH_W{1'b0}};
        end else if (w_restart) begin
            r_phase <= PH_HALF;
        end else if (w_tick) begin
            r_phase <= r_phase + PH_W'(1);
        end
    end

    assign bus.CFG_READY_OUT       = ~r_shd_full;
    assign bus.SUBSAMPLE_PULSE_OUT = w_tick;
    assign bus.BAUD_PULSE_OUT      = w_baud;
`ifdef UART_BAUD_GEN_PHASE_OUT_EN
    assign bus.PHASE_OUT           = r_phase;
`endif

endmodule

// File: tb/tb_spio_uart_frac_baud_gen.sv
// Directed bench for spio_uart_frac_baud_gen: defaults, reconfiguration, clamping,
// fractional alternation, resync, enable freeze and reset with a pending config.
module tb_spio_uart_frac_baud_gen;

    logic clk = 1'b0;
    logic rst_n, en, resync;
    int   n_vec = 0;
    int   n_err = 0;

    spio_uart_frac_baud_gen_if bus ();

    spio_uart_frac_baud_gen dut (
        .CLK_IN     (clk),
        .RESET_N_IN (rst_n),
        .ENABLE_IN  (en),
        .RESYNC_IN  (resync),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int unsigned got, input int unsigned exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_sub(input int limit, output int n, output bit b);
        n = 0;
        do begin
            step();
            n++;
        end while (!bus.SUBSAMPLE_PULSE_OUT && n < limit);
        b = bus.BAUD_PULSE_OUT;
        if (!bus.SUBSAMPLE_PULSE_OUT) check_val("wait_sub_timeout", n, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        int n, total, errs, cnt, hi;
        bit b;
        rst_n = 1'b0; en = 1'b1; resync = 1'b0;
        bus.CFG_VALID_IN = 1'b0; bus.CFG_DIV_INT_IN = 12'd0; bus.CFG_DIV_FRAC_IN = 8'd0;

        // reset state
        repeat (3) step();
        check_val("rst_ready", bus.CFG_READY_OUT, 1);
        check_val("rst_sub", bus.SUBSAMPLE_PULSE_OUT, 0);
        check_val("rst_baud", bus.BAUD_PULSE_OUT, 0);
        rst_n = 1'b1;

        // defaults: first subsample at 107, 256 periods of 108/109 totalling 27778
        wait_sub(200, n, b);
        check_val("first_sub_cycle", n, 107);
        check_val("first_sub_not_baud", b, 0);
        total = 0; errs = 0; cnt = 0; hi = 0;
        for (int k = 1; k <= 256; k++) begin
            wait_sub(200, n, b);
            total += n;
            if (n != 108 && n != 109) errs++;
            if (b) begin
                cnt++;
                if ((k + 1) % 8 != 0) hi++;
            end
        end
        check_val("default_total_clocks", total, 27778);
        check_val("default_period_range_errs", errs, 0);
        check_val("default_baud_count", cnt, 32);
        check_val("default_baud_misaligned", hi, 0);

        // config 4/0 mid-period; second offer while not ready is ignored
        do_reset();
        repeat (50) step();
        bus.CFG_VALID_IN = 1'b1; bus.CFG_DIV_INT_IN = 12'd4; bus.CFG_DIV_FRAC_IN = 8'd0;
        check_val("cfg_ready_idle", bus.CFG_READY_OUT, 1);
        step();
        bus.CFG_DIV_INT_IN = 12'd9;
        check_val("cfg_ready_fell", bus.CFG_READY_OUT, 0);
        repeat (3) step();
        bus.CFG_VALID_IN = 1'b0;
        n = 0; hi = 0;
        do begin
            step();
            n++;
            if (bus.CFG_READY_OUT && !bus.BAUD_PULSE_OUT) hi++;
        end while (!bus.BAUD_PULSE_OUT && n < 3000);
        check_val("cfg_baud_seen", bus.BAUD_PULSE_OUT, 1);
        check_val("cfg_ready_low_until_baud", hi, 0);
        check_val("cfg_ready_at_baud", bus.CFG_READY_OUT, 0);
        step();
        check_val("cfg_ready_after_copy", bus.CFG_READY_OUT, 1);
        wait_sub(50, n, b);
        check_val("fast_first_period", n, 3);
        errs = 0;
        for (int k = 2; k <= 8; k++) begin
            wait_sub(50, n, b);
            if (n != 4) errs++;
            if (b && k != 8) errs++;
        end
        check_val("fast_period_errs", errs, 0);
        check_val("fast_baud_32_clocks", b, 1);

        // resync at phase 2, on a cycle where a subsample was due
        wait_sub(50, n, b);
        wait_sub(50, n, b);
        repeat (4) step();
        resync = 1'b1;
        #1;
        check_val("resync_suppress_sub", bus.SUBSAMPLE_PULSE_OUT, 0);
        check_val("resync_suppress_baud", bus.BAUD_PULSE_OUT, 0);
        step();
        resync = 1'b0;
        total = 1; cnt = 0;
        do begin
            wait_sub(50, n, b);
            total += n;
            cnt++;
        end while (!b && cnt < 8);
        check_val("resync_subs_to_baud", cnt, 4);
        check_val("resync_clocks_to_baud", total, 16);

        // DIV_INT=1 clamps to 2; applied while disabled
        en = 1'b0;
        bus.CFG_VALID_IN = 1'b1; bus.CFG_DIV_INT_IN = 12'd1; bus.CFG_DIV_FRAC_IN = 8'd0;
        #1;
        check_val("disabled_no_sub", bus.SUBSAMPLE_PULSE_OUT, 0);
        check_val("disabled_cfg_ready", bus.CFG_READY_OUT, 1);
        step();
        bus.CFG_VALID_IN = 1'b0;
        check_val("disabled_ready_fell", bus.CFG_READY_OUT, 0);
        step();
        check_val("disabled_ready_rose", bus.CFG_READY_OUT, 1);
        en = 1'b1; resync = 1'b1;
        step();
        resync = 1'b0;
        wait_sub(50, n, b);
        check_val("div1_first_sub", n, 1);
        errs = 0;
        for (int k = 2; k <= 4; k++) begin
            wait_sub(50, n, b);
            if (n != 2) errs++;
        end
        check_val("div1_period_errs", errs, 0);
        check_val("div1_baud_after_4", b, 1);

        // DIV 2 + 128/256 via pending shadow applied by resync: periods 2,3,2,3
        bus.CFG_VALID_IN = 1'b1; bus.CFG_DIV_INT_IN = 12'd2; bus.CFG_DIV_FRAC_IN = 8'd128;
        step();
        bus.CFG_VALID_IN = 1'b0; resync = 1'b1;
        step();
        resync = 1'b0;
        check_val("resync_copy_ready", bus.CFG_READY_OUT, 1);
        wait_sub(50, n, b);
        errs = 0;
        for (int k = 0; k < 4; k++) begin
            wait_sub(50, n, b);
            if (n != ((k % 2 == 0) ? 2 : 3)) errs++;
        end
        check_val("frac_alternate_errs", errs, 0);

        // enable low for 50 cycles mid-period
        do_reset();
        repeat (40) step();
        en = 1'b0;
        bus.CFG_VALID_IN = 1'b1; bus.CFG_DIV_INT_IN = 12'd5; bus.CFG_DIV_FRAC_IN = 8'd0;
        check_val("hold_cfg_ready", bus.CFG_READY_OUT, 1);
        cnt = 0;
        for (int i = 1; i <= 50; i++) begin
            step();
            if (bus.SUBSAMPLE_PULSE_OUT || bus.BAUD_PULSE_OUT) cnt++;
            if (i == 1) begin
                bus.CFG_VALID_IN = 1'b0;
                check_val("hold_ready_fell", bus.CFG_READY_OUT, 0);
            end
            if (i == 2) check_val("hold_ready_rose", bus.CFG_READY_OUT, 1);
        end
        check_val("hold_pulses", cnt, 0);
        en = 1'b1;
        wait_sub(200, n, b);
        check_val("hold_resume_residue", n, 67);
        wait_sub(50, n, b);
        check_val("hold_new_div_period", n, 5);

        // reset with config pending discards it
        do_reset();
        repeat (20) step();
        bus.CFG_VALID_IN = 1'b1; bus.CFG_DIV_INT_IN = 12'd4; bus.CFG_DIV_FRAC_IN = 8'd0;
        step();
        bus.CFG_VALID_IN = 1'b0;
        check_val("pend_ready_low", bus.CFG_READY_OUT, 0);
        rst_n = 1'b0;
        step();
        check_val("pend_rst_ready", bus.CFG_READY_OUT, 1);
        check_val("pend_rst_sub", bus.SUBSAMPLE_PULSE_OUT, 0);
        check_val("pend_rst_baud", bus.BAUD_PULSE_OUT, 0);
        rst_n = 1'b1;
        wait_sub(200, n, b);
        check_val("pend_first_sub", n, 107);
        wait_sub(200, n, b);
        check_val("pend_default_period", n, 108);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
